// File: rtl/dec2_neuron.sv
// -----------------------------------------------------------------------------
// dec2_neuron
//   Streaming fixed-point neuron. It accepts N_IN signed activations, one per
//   handshake, and multiplies beat k by weight w_k. It then adds a bias, scales
//   the sum back to the Q format with floor rounding, saturates the result and,
//   when ACT == 1, applies a ReLU.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (highest priority)
//   clear      synchronous abort of the current dot product / pending result
//   w_flat     packed weights, w_i = w_flat[i*DATA_WIDTH +: DATA_WIDTH]
//   bias       signed bias, same Q format as the data
//   in_valid   in_data beat is valid
//   in_ready   block accepts a beat (only while accumulating)
//   in_data    signed activation
//   out_valid  out_data holds a finished result
//   out_ready  downstream accepts the result
//   out_data   signed neuron result, held stable until accepted
// -----------------------------------------------------------------------------
module dec2_neuron #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int N_IN       = 16,
    parameter int ACT        = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic [N_IN*DATA_WIDTH-1:0] w_flat,
    input  logic [DATA_WIDTH-1:0]      bias,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data
);

    // The accumulator holds N_IN full-width products, so it can never wrap.
    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = PW + $clog2(N_IN);
    localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
    // The sum width covers both the accumulator and the shifted bias, plus one
    // bit so that adding the two cannot overflow either.
    localparam int BW = DATA_WIDTH + FRAC_BITS;
    localparam int SW = ((AW > BW) ? AW : BW) + 1;

    localparam logic signed [SW-1:0] ONE   = SW'(1);
    localparam logic signed [SW-1:0] R_MAX = (ONE <<< (DATA_WIDTH - 1)) - ONE;
    localparam logic signed [SW-1:0] R_MIN = -(ONE <<< (DATA_WIDTH - 1));
    localparam logic [CW-1:0]        LAST  = CW'(N_IN - 1);

    typedef enum logic [1:0] {
        S_ACC = 2'd0,
        S_FIN = 2'd1,
        S_OUT = 2'd2
    } state_t;

    state_t                        state_reg, state_next;
    logic signed [AW-1:0]          acc_reg, acc_next;
    logic [CW-1:0]                 count_reg, count_next;
    logic [DATA_WIDTH-1:0]         out_data_reg, out_data_next;

    // ---------------------------------------------------------------------
    // Weight unpacking and multiply
    // ---------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0]  w_arr [N_IN];

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_w
            assign w_arr[gi] = w_flat[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic signed [DATA_WIDTH-1:0]  w_sel;
    logic signed [PW-1:0]          product;
    logic signed [AW-1:0]          product_ext;

    assign w_sel       = w_arr[count_reg];
    assign product     = $signed(in_data) * w_sel;
    assign product_ext = AW'(product);

    // ---------------------------------------------------------------------
    // Finalisation: bias, rescale, saturate, activation
    // ---------------------------------------------------------------------
    logic signed [SW-1:0]          bias_ext;
    logic signed [SW-1:0]          sum;
    logic signed [SW-1:0]          shifted;
    logic signed [DATA_WIDTH-1:0]  r_sat;
    logic signed [DATA_WIDTH-1:0]  r_final;

    assign bias_ext = SW'($signed(bias));
    assign sum      = SW'(acc_reg) + (bias_ext <<< FRAC_BITS);
    // Arithmetic shift gives floor rounding towards minus infinity.
    assign shifted  = sum >>> FRAC_BITS;

    always_comb begin
        r_sat = shifted[DATA_WIDTH-1:0];
        if (shifted > R_MAX) begin
            r_sat = R_MAX[DATA_WIDTH-1:0];
        end else if (shifted < R_MIN) begin
            r_sat = R_MIN[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        r_final = r_sat;
        if (ACT == 1 && r_sat[DATA_WIDTH-1]) begin
            r_final = '0;
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        count_next    = count_reg;
        out_data_next = out_data_reg;

        case (state_reg)
            S_ACC: begin
                if (in_valid) begin
                    acc_next = acc_reg + product_ext;
                    if (count_reg == LAST) begin
                        count_next = '0;
                        state_next = S_FIN;
                    end else begin
                        count_next = count_reg + CW'(1);
                    end
                end
            end
            S_FIN: begin
                out_data_next = r_final;
                state_next    = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_next = S_ACC;
                    acc_next   = '0;
                    count_next = '0;
                end
            end
            default: begin
                state_next = S_ACC;
                acc_next   = '0;
                count_next = '0;
            end
        endcase

        // An abort overrides everything except reset, including a beat
        // that arrives on the same edge.
        if (clear) begin
            state_next = S_ACC;
            acc_next   = '0;
            count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_ACC;
            acc_reg      <= '0;
            count_reg    <= '0;
            out_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            count_reg    <= count_next;
            out_data_reg <= out_data_next;
        end
    end

    assign in_ready  = (state_reg == S_ACC);
    assign out_valid = (state_reg == S_OUT);
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_dec2_neuron.sv
// -----------------------------------------------------------------------------
// tb_dec2_neuron
//   Self-checking bench for dec2_neuron. Two instances share all inputs:
//   u_lin (ACT = 0) and u_relu (ACT = 1). A reference model computes the
//   expected result of each dot product when its stimulus is driven. The
//   result is pushed to a per-instance queue and popped at the output
//   handshake for comparison.
// -----------------------------------------------------------------------------
module tb_dec2_neuron;

    localparam int DW = 16;
    localparam int FB = 8;
    localparam int N  = 16;

    typedef logic [DW-1:0] vec_t [N];

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clear;
    logic [N*DW-1:0] w_flat;
    logic [DW-1:0]   bias;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            out_ready;

    logic            in_ready_l, out_valid_l;
    logic            in_ready_r, out_valid_r;
    logic [DW-1:0]   out_data_l, out_data_r;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] exp_lin_q [$];
    logic [DW-1:0] exp_relu_q [$];

    always #5 clk = ~clk;

    dec2_neuron #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .N_IN(N), .ACT(0)) u_lin (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .w_flat    (w_flat),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready_l),
        .in_data   (in_data),
        .out_valid (out_valid_l),
        .out_ready (out_ready),
        .out_data  (out_data_l)
    );

    dec2_neuron #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .N_IN(N), .ACT(1)) u_relu (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .w_flat    (w_flat),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready_r),
        .in_data   (in_data),
        .out_valid (out_valid_r),
        .out_ready (out_ready),
        .out_data  (out_data_r)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] model(input vec_t xs, input vec_t ws,
                                            input logic [DW-1:0] b, input bit relu);
        longint acc;
        longint r;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            acc += longint'($signed(xs[i])) * longint'($signed(ws[i]));
        end
        acc += longint'($signed(b)) * (longint'(1) << FB);
        r = acc >>> FB;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return r[DW-1:0];
    endfunction

    function automatic vec_t fill(input logic [DW-1:0] v);
        vec_t t;
        for (int i = 0; i < N; i++) t[i] = v;
        return t;
    endfunction

    task automatic set_weights(input vec_t ws);
        for (int i = 0; i < N; i++) w_flat[i*DW +: DW] = ws[i];
    endtask

    function automatic vec_t get_weights();
        vec_t t;
        for (int i = 0; i < N; i++) t[i] = w_flat[i*DW +: DW];
        return t;
    endfunction

    // Drives one full dot product and checks it through the output handshake.
    task automatic run_dot(input string name, input vec_t xs, input logic [DW-1:0] b,
                           input int hold, input bit gaps);
        vec_t ws;
        int   edges;
        logic [DW-1:0] held_l, held_r, exp_l, exp_r;
        ws   = get_weights();
        bias = b;
        exp_lin_q.push_back(model(xs, ws, b, 1'b0));
        exp_relu_q.push_back(model(xs, ws, b, 1'b1));

        check_val({name, "_idle"}, {60'd0, in_ready_l, in_ready_r, out_valid_l, out_valid_r}, 64'hC);
        for (int k = 0; k < N; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = 16'(($urandom));
                    tick();
                end
            end
            in_data  = xs[k];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        // The accepting edge counts as edge 1.
        edges = 1;
        check_val({name, "_fin_flags"}, {60'd0, in_ready_l, in_ready_r, out_valid_l, out_valid_r}, 64'h0);
        while (!(out_valid_l && out_valid_r) && edges < 12) begin
            tick();
            edges++;
        end
        check_val({name, "_edges_to_valid"}, 64'(edges), 64'd2);

        held_l = out_data_l;
        held_r = out_data_r;
        for (int h = 0; h < hold; h++) begin
            tick();
            check_val({name, "_hold"},
                      {28'd0, out_data_l, out_data_r, in_ready_l, in_ready_r, out_valid_l, out_valid_r},
                      {28'd0, held_l, held_r, 4'b0011});
        end

        exp_l = (exp_lin_q.size() > 0) ? exp_lin_q.pop_front() : 16'hxxxx;
        exp_r = (exp_relu_q.size() > 0) ? exp_relu_q.pop_front() : 16'hxxxx;
        check_val({name, "_out_lin"}, 64'(out_data_l), 64'(exp_l));
        check_val({name, "_out_relu"}, 64'(out_data_r), 64'(exp_r));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val({name, "_post_hs"}, {60'd0, in_ready_l, in_ready_r, out_valid_l, out_valid_r}, 64'hC);
    endtask

    // Feeds a partial dot product of x = 1.0 beats.
    task automatic partial(input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            in_data  = 16'h0100;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        vec_t xs;
        vec_t ws;

        rst_n     = 1'b0;
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        out_ready = 1'b1;
        bias      = '0;
        w_flat    = '0;
        repeat (3) tick();
        rst_n     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("reset_flags", {60'd0, in_ready_l, in_ready_r, out_valid_l, out_valid_r}, 64'hC);
        check_val("reset_data", {32'd0, out_data_l, out_data_r}, 64'h0);

        // Unit weights and inputs; back-pressure held for 5 cycles.
        set_weights(fill(16'h0100));
        run_dot("unit", fill(16'h0100), 16'h0000, 5, 1'b0);

        // Positive and negative saturation.
        set_weights(fill(16'h7fff));
        run_dot("sat_pos", fill(16'h7fff), 16'h7fff, 0, 1'b0);
        set_weights(fill(16'h8000));
        run_dot("sat_neg", fill(16'h7fff), 16'h0000, 1, 1'b0);

        // Negative result: linear output and ReLU clamp.
        set_weights(fill(16'hff00));
        run_dot("neg_bias", fill(16'h0100), 16'hff9a, 0, 1'b1);

        // Floor rounding of a tiny negative product.
        ws    = fill(16'h0100);
        ws[0] = 16'hffff;
        set_weights(ws);
        xs    = fill(16'h0000);
        xs[0] = 16'h0001;
        run_dot("floor", xs, 16'h0000, 0, 1'b0);

        // Reset aborts a partial sum.
        set_weights(fill(16'h0100));
        partial(7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_val("rst_abort", {28'd0, out_data_l, out_data_r, in_ready_l, in_ready_r, out_valid_l, out_valid_r},
                  64'hC);
        run_dot("after_rst", fill(16'h0100), 16'h0000, 0, 1'b0);

        // Clear aborts a partial sum and wins over a coincident beat.
        partial(7);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h7fff;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check_val("clr_abort", {60'd0, in_ready_l, in_ready_r, out_valid_l, out_valid_r}, 64'hC);
        run_dot("after_clr", fill(16'h0100), 16'h0000, 0, 1'b0);

        // Clear drops a pending result.
        partial(16);
        tick();
        check_val("pend_valid", {62'd0, out_valid_l, out_valid_r}, 64'h3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_val("pend_drop", {60'd0, in_ready_l, in_ready_r, out_valid_l, out_valid_r}, 64'hC);

        // Random small operands with idle gaps between beats.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) begin
                ws[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
                xs[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
            end
            set_weights(ws);
            run_dot($sformatf("rand%0d", t), xs, 16'($urandom), $urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dec2_neuron.md
DEC2_NEURON -- requirements
Module: dec2_neuron

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed fixed-point word width for inputs, weights, bias and output.
REQ-002 SHALL have parameter FRAC_BITS, default 8, fractional bits (Q8.8 at defaults).
REQ-003 SHALL have parameter N_IN, default 16, input beats per output.
REQ-004 SHALL have parameter ACT, default 1: 0 = linear, 1 = ReLU.
REQ-005 SHALL use one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-007 clear  input  1  synchronous abort of the current dot product.
REQ-008 w_flat  input  N_IN*DATA_WIDTH  weights; w_i = w_flat[i*DATA_WIDTH +: DATA_WIDTH], driven from the layer weight ROM.
REQ-009 bias  input  DATA_WIDTH  signed bias in Q format.
REQ-010 in_valid  input  1  in_data beat is valid.
REQ-011 in_ready  output  1  block accepts a beat.
REQ-012 in_data  input  DATA_WIDTH  signed activation x_i.
REQ-013 out_valid  output  1  out_data is valid.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 out_data  output  DATA_WIDTH  signed neuron result.

Function
REQ-016 SHALL implement the FSM states S_ACC, S_FIN and S_OUT.
REQ-017 In S_ACC, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-018 A beat SHALL be accepted on an edge where in_valid && in_ready; beat k (0-based count) multiplies by w_k.
REQ-019 On each accept: product = signed DATA_WIDTH x DATA_WIDTH to 2*DATA_WIDTH bits; acc += product, where acc is 2*DATA_WIDTH+$clog2(N_IN) bits signed; count increments.
REQ-020 The accumulator SHALL not wrap for any input values.
REQ-021 On the accept with count == N_IN-1, the FSM SHALL go to S_FIN and count SHALL return to 0.
REQ-022 In S_FIN (exactly one cycle), the block SHALL compute sum = acc + (bias sign-extended, << FRAC_BITS).
REQ-023 In S_FIN, the block SHALL compute r = sum >>> FRAC_BITS (arithmetic shift; floor rounding).
REQ-024 In S_FIN, r SHALL saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-025 In S_FIN, if ACT == 1 and r < 0, r SHALL be replaced by 0.
REQ-026 The result of S_FIN SHALL be registered into out_data, and the FSM SHALL go to S_OUT.
REQ-027 In S_FIN and S_OUT, in_ready SHALL be 0.
REQ-028 Latency: out_valid SHALL rise 2 clock edges after the edge that accepts the final beat.
REQ-029 In S_OUT, out_valid SHALL be 1, and out_data SHALL be held stable while out_ready = 0.
REQ-030 When out_valid && out_ready on an edge, the FSM SHALL go to S_ACC with acc = 0 and count = 0.
REQ-031 A new beat SHALL be acceptable on the next edge after that handshake; no beat is accepted on the handshake edge itself.
REQ-032 clear = 1 (with rst_n = 1) on an edge SHALL force S_ACC with acc = 0, count = 0 and out_valid = 0 from any state; any in_data beat on that edge is discarded.
REQ-033 If clear and an accept coincide, clear SHALL win.
REQ-034 Weights and bias SHALL be sampled combinationally at use (w_k at its accept, bias in S_FIN); they are static in normal use.

Reset
REQ-035 When rst_n = 0 on a rising edge, the block SHALL enter S_ACC with acc = 0, count = 0, out_valid = 0 and out_data = 0.
REQ-036 After reset, in_ready SHALL be 1 in the first cycle.
REQ-037 Reset SHALL take priority over clear and over any handshake.
REQ-038 Reset SHALL abort a partial sum mid-operation with no output produced.

Verification
REQ-039 All w = 0x0100, bias = 0, 16 beats of x = 0x0100 -> out_data = 0x1000, exactly 2 edges after the 16th accept.
REQ-040 All w = 0x7fff, all x = 0x7fff, bias = 0x7fff -> out_data = 0x7fff (saturated); all w = 0x8000, x = 0x7fff, ACT = 0 -> out_data = 0x8000.
REQ-041 All w = 0xff00, x = 0x0100, bias = 0xff9a -> ACT = 0: out_data = 0xef9a; ACT = 1: out_data = 0x0000.
REQ-042 w0 = 0xffff, x0 = 0x0001, all other x = 0, bias = 0, ACT = 0 -> out_data = 0xffff (floor rounding).
REQ-043 Hold out_ready = 0 for 5 cycles with out_valid = 1 -> out_data stable and in_ready = 0 throughout; then the handshake occurs and in_ready = 1 on the next cycle.
REQ-044 After 7 beats, pulse rst_n = 0 (and separately clear = 1) for one cycle, then run the REQ-039 stimulus -> out_data = 0x1000 with no spurious out_valid.
